// File: rtl/pmem_port_arbiter_if.sv
// Signal bundle between the IF/LS requesters, the pmem port arbiter and physical memory.
// slave: arbiter view; master: requester/memory environment view.
interface pmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              if_read;
  logic [ADDR_W-1:0] if_address;
  logic [DATA_W-1:0] if_rdata;
  logic              if_resp;

  logic              ls_read;
  logic              ls_write;
  logic [ADDR_W-1:0] ls_address;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [DATA_W-1:0] pmem_wdata;
  logic [DATA_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  if_read, if_address, ls_read, ls_write, ls_address, ls_wdata,
           pmem_rdata, pmem_resp,
    output if_rdata, if_resp, ls_rdata, ls_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output if_read, if_address, ls_read, ls_write, ls_address, ls_wdata,
           pmem_rdata, pmem_resp,
    input  if_rdata, if_resp, ls_rdata, ls_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_port_arbiter.sv
// Shares one pmem port between IF (read-only) and LS (read/write); one transaction in flight.
// Define PMEM_ARB_RR_EN for round-robin arbitration; default is fixed LS-over-IF priority.
module pmem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                clk,
  input logic                rst,
  pmem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, LS_BUSY, RECOVER} state_t;

  state_t            state, state_next;
  logic              read_q, read_next;
  logic              write_q, write_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [DATA_W-1:0] wdata_q, wdata_next;
  logic              ls_req, grant_ls, grant_if;
  logic              if_resp_c, ls_resp_c;

  assign ls_req = bus.ls_read | bus.ls_write;

`ifdef PMEM_ARB_RR_EN
  localparam logic OWNER_LS = 1'b0;
  localparam logic OWNER_IF = 1'b1;
  logic last_owner;

  // On contention the requester that did not win last time gets the port.
  assign grant_ls = ls_req & (~bus.if_read | (last_owner == OWNER_IF));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWNER_LS;
    end else if (state == IDLE && grant_ls) begin
      last_owner <= OWNER_LS;
    end else if (state == IDLE && grant_if) begin
      last_owner <= OWNER_IF;
    end
  end
`else
  assign grant_ls = ls_req;
`endif

  assign grant_if = bus.if_read & ~grant_ls;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_next;
      read_q  <= read_next;
      write_q <= write_next;
      addr_q  <= addr_next;
      wdata_q <= wdata_next;
    end
  end

  // Command is latched at grant and held untouched until pmem_resp.
  always_comb begin
    state_next = state;
    read_next  = read_q;
    write_next = write_q;
    addr_next  = addr_q;
    wdata_next = wdata_q;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_next = LS_BUSY;
          read_next  = bus.ls_read & ~bus.ls_write;
          write_next = bus.ls_write;
          addr_next  = bus.ls_address;
          wdata_next = bus.ls_wdata;
        end else if (grant_if) begin
          state_next = IF_BUSY;
          read_next  = 1'b1;
          write_next = 1'b0;
          addr_next  = bus.if_address;
        end
      end
      IF_BUSY, LS_BUSY: begin
        if (bus.pmem_resp) begin
          state_next = RECOVER;
          read_next  = 1'b0;
          write_next = 1'b0;
        end
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign if_resp_c = (state == IF_BUSY) & bus.pmem_resp;
  assign ls_resp_c = (state == LS_BUSY) & bus.pmem_resp;

  assign bus.if_resp      = if_resp_c;
  assign bus.ls_resp      = ls_resp_c;
  assign bus.if_rdata     = if_resp_c ? bus.pmem_rdata : '0;
  assign bus.ls_rdata     = ls_resp_c ? bus.pmem_rdata : '0;
  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_pmem_port_arbiter.sv
// Directed self-checking bench for pmem_port_arbiter.
// Expectations follow the default build unless PMEM_ARB_RR_EN is defined.
module tb_pmem_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  pmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.if_read = 1'b0; bus.if_address = '0;
    bus.ls_read = 1'b0; bus.ls_write = 1'b0; bus.ls_address = '0; bus.ls_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;
    step(); step();
    checks++; if (bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rst_pmem_read: got %0b expected 0", bus.pmem_read); end
    checks++; if (bus.pmem_write !== 1'b0) begin errors++; $display("FAIL rst_pmem_write: got %0b expected 0", bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h0) begin errors++; $display("FAIL rst_pmem_address: got %h expected 0", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== 32'h0) begin errors++; $display("FAIL rst_pmem_wdata: got %h expected 0", bus.pmem_wdata); end
    checks++; if (bus.if_resp !== 1'b0 || bus.ls_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got if=%0b ls=%0b expected 0 0", bus.if_resp, bus.ls_resp); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got if=%h ls=%h expected 0 0", bus.if_rdata, bus.ls_rdata); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    bus.if_read = 1'b1; bus.if_address = 32'h0000_0040;
    step();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL if_strobe: got rd=%0b wr=%0b expected 1 0", bus.pmem_read, bus.pmem_write); end
    checks++; if (bus.pmem_address !== 32'h40) begin errors++; $display("FAIL if_address: got %h expected 40", bus.pmem_address); end
    checks++; if (bus.if_resp !== 1'b0) begin errors++; $display("FAIL if_early_resp: got %0b expected 0", bus.if_resp); end
    step();
    checks++; if (bus.pmem_read !== 1'b1) begin errors++; $display("FAIL if_strobe_hold: got %0b expected 1", bus.pmem_read); end
    step();
    bus.pmem_rdata = 32'hDEAD_BEEF; bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.if_resp !== 1'b1) begin errors++; $display("FAIL if_resp: got %0b expected 1", bus.if_resp); end
    checks++; if (bus.if_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL if_rdata: got %h expected deadbeef", bus.if_rdata); end
    checks++; if (bus.ls_resp !== 1'b0) begin errors++; $display("FAIL if_ls_resp: got %0b expected 0", bus.ls_resp); end
    step();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0; bus.if_read = 1'b0;
    checks++; if (bus.pmem_read !== 1'b0 || bus.if_resp !== 1'b0) begin errors++; $display("FAIL if_release: got rd=%0b resp=%0b expected 0 0", bus.pmem_read, bus.if_resp); end
    step();
  endtask

  task automatic test_ls_store();
    bus.ls_write = 1'b1; bus.ls_address = 32'h100; bus.ls_wdata = 32'h1234_5678;
    step();
    checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL st_strobe: got wr=%0b rd=%0b expected 1 0", bus.pmem_write, bus.pmem_read); end
    checks++; if (bus.pmem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_wdata: got %h expected 12345678", bus.pmem_wdata); end
    bus.ls_address = 32'h200; bus.ls_wdata = 32'h0BAD_0BAD;
    step();
    checks++; if (bus.pmem_address !== 32'h100) begin errors++; $display("FAIL st_addr_hold: got %h expected 100", bus.pmem_address); end
    checks++; if (bus.pmem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL st_wdata_hold: got %h expected 12345678", bus.pmem_wdata); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.ls_resp !== 1'b1 || bus.if_resp !== 1'b0) begin errors++; $display("FAIL st_resp: got ls=%0b if=%0b expected 1 0", bus.ls_resp, bus.if_resp); end
    step();
    bus.pmem_resp = 1'b0; bus.ls_write = 1'b0;
    checks++; if (bus.pmem_write !== 1'b0 || bus.ls_resp !== 1'b0) begin errors++; $display("FAIL st_release: got wr=%0b resp=%0b expected 0 0", bus.pmem_write, bus.ls_resp); end
    step();
  endtask

  task automatic test_both_ops();
    bus.ls_read = 1'b1; bus.ls_write = 1'b1; bus.ls_address = 32'h180; bus.ls_wdata = 32'hA5A5_5A5A;
    step();
    checks++; if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0) begin errors++; $display("FAIL rw_as_write: got wr=%0b rd=%0b expected 1 0", bus.pmem_write, bus.pmem_read); end
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.ls_resp !== 1'b1) begin errors++; $display("FAIL rw_resp: got %0b expected 1", bus.ls_resp); end
    step();
    bus.pmem_resp = 1'b0; bus.ls_read = 1'b0; bus.ls_write = 1'b0;
    step();
  endtask

  task automatic test_priority();
`ifdef PMEM_ARB_RR_EN
    bit [0:2] exp_ls = 3'b010;
`else
    bit [0:2] exp_ls = 3'b110;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.if_read = 1'b1; bus.if_address = 32'h40;
    bus.ls_read = 1'b1; bus.ls_address = 32'h300;
    for (int k = 0; k < 3; k++) begin
      logic        ls_own;
      logic [31:0] rd;
      ls_own = exp_ls[k];
      rd     = 32'(32'h1000 + k);
      step();
      checks++; if (bus.pmem_address !== (ls_own ? 32'h300 : 32'h40)) begin errors++; $display("FAIL prio_grant%0d: got addr %h expected %h", k, bus.pmem_address, ls_own ? 32'h300 : 32'h40); end
      step();
      bus.pmem_rdata = rd; bus.pmem_resp = 1'b1;
      #1;
      checks++; if (bus.ls_resp !== ls_own || bus.if_resp !== ~ls_own) begin errors++; $display("FAIL prio_resp%0d: got ls=%0b if=%0b expected %0b %0b", k, bus.ls_resp, bus.if_resp, ls_own, ~ls_own); end
      checks++; if ((ls_own ? bus.ls_rdata : bus.if_rdata) !== rd) begin errors++; $display("FAIL prio_rdata%0d: got %h expected %h", k, ls_own ? bus.ls_rdata : bus.if_rdata, rd); end
      step();
      bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
      if (k == 1) bus.ls_read = 1'b0;
      step();
    end
    bus.if_read = 1'b0;
    step();
  endtask

  task automatic test_drop_mid();
    bus.if_read = 1'b1; bus.if_address = 32'h44;
    step();
    bus.if_read = 1'b0; bus.if_address = 32'h88;
    step();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h44) begin errors++; $display("FAIL drop_hold: got rd=%0b addr=%h expected 1 44", bus.pmem_read, bus.pmem_address); end
    bus.pmem_rdata = 32'h0000_5555; bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.if_resp !== 1'b1 || bus.if_rdata !== 32'h5555) begin errors++; $display("FAIL drop_resp: got resp=%0b data=%h expected 1 5555", bus.if_resp, bus.if_rdata); end
    step();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    step();
  endtask

  task automatic test_spurious_resp();
    bus.pmem_rdata = 32'hFFFF_FFFF; bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.if_resp !== 1'b0 || bus.ls_resp !== 1'b0) begin errors++; $display("FAIL spur_resp: got if=%0b ls=%0b expected 0 0", bus.if_resp, bus.ls_resp); end
    checks++; if (bus.if_rdata !== 32'h0 || bus.ls_rdata !== 32'h0) begin errors++; $display("FAIL spur_rdata: got if=%h ls=%h expected 0 0", bus.if_rdata, bus.ls_rdata); end
    step();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    checks++; if (bus.pmem_read !== 1'b0 || bus.pmem_write !== 1'b0) begin errors++; $display("FAIL spur_strobe: got rd=%0b wr=%0b expected 0 0", bus.pmem_read, bus.pmem_write); end
    bus.if_read = 1'b1; bus.if_address = 32'h20;
    step();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h20) begin errors++; $display("FAIL spur_next_grant: got rd=%0b addr=%h expected 1 20", bus.pmem_read, bus.pmem_address); end
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0; bus.if_read = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.ls_write = 1'b1; bus.ls_address = 32'h100; bus.ls_wdata = 32'h7777_0000;
    step();
    checks++; if (bus.pmem_write !== 1'b1) begin errors++; $display("FAIL rmid_strobe: got %0b expected 1", bus.pmem_write); end
    rst = 1'b1;
    #1;
    checks++; if (bus.pmem_write !== 1'b0 || bus.pmem_read !== 1'b0 || bus.pmem_address !== 32'h0) begin errors++; $display("FAIL rmid_clear: got wr=%0b rd=%0b addr=%h expected 0 0 0", bus.pmem_write, bus.pmem_read, bus.pmem_address); end
    step();
    rst = 1'b0; bus.ls_write = 1'b0;
    step();
    bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.ls_resp !== 1'b0 || bus.if_resp !== 1'b0) begin errors++; $display("FAIL rmid_late_resp: got ls=%0b if=%0b expected 0 0", bus.ls_resp, bus.if_resp); end
    step();
    bus.pmem_resp = 1'b0;
    bus.ls_read = 1'b1; bus.ls_address = 32'h200;
    step();
    checks++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 32'h200) begin errors++; $display("FAIL rmid_regrant: got rd=%0b addr=%h expected 1 200", bus.pmem_read, bus.pmem_address); end
    bus.pmem_rdata = 32'h0000_00AB; bus.pmem_resp = 1'b1;
    #1;
    checks++; if (bus.ls_resp !== 1'b1 || bus.ls_rdata !== 32'hAB) begin errors++; $display("FAIL rmid_resp: got resp=%0b data=%h expected 1 ab", bus.ls_resp, bus.ls_rdata); end
    step();
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0; bus.ls_read = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_ls_store();
    test_both_ops();
    test_priority();
    test_drop_mid();
    test_spurious_resp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
